// File: rtl/census_win_seq.sv
// census_win_seq
//   Sequencer for the census/Hamming custom-instruction unit. It takes an
//   11x11 window one row beat at a time and drives the unit through the
//   full operation sequence for that window: a clear, two loads per row,
//   one compare, and then reads of the result words. It assembles the
//   120-bit census code and presents it downstream on a valid/ready
//   handshake.
// Ports
//   iClk, iReset            clock; synchronous active-high reset
//   iEnable                 run windows back to back while high
//   iRowData/iRowValid      one 88-bit window row per beat (pixel k at [8k+7:8k])
//   oRowReady               row beat is accepted when this and iRowValid are high
//   iCenter                 centre pixel, sampled when row 10 is accepted
//   oCode/oCodeValid        census code out, held until iCodeReady
//   iCodeReady              downstream accepts the code
//   oCeA/oCeB/oCeOp         census unit operands and opcode
//   oCeStart/oCeClkEn       census unit start strobe and clock enable
//   iCeRes                  census unit result, sampled at a fixed latency
//   oBusy                   high whenever the sequencer is not IDLE
module census_win_seq #(
    parameter int WIN    = 11,
    parameter int CODE_W = WIN * WIN - 1
) (
    input  logic                iClk,
    input  logic                iReset,
    input  logic                iEnable,
    input  logic [8*WIN-1:0]    iRowData,
    input  logic                iRowValid,
    output logic                oRowReady,
    input  logic [7:0]          iCenter,
    output logic [CODE_W-1:0]   oCode,
    output logic                oCodeValid,
    input  logic                iCodeReady,
    output logic [31:0]         oCeA,
    output logic [31:0]         oCeB,
    output logic [3:0]          oCeOp,
    output logic                oCeStart,
    output logic                oCeClkEn,
    input  logic [31:0]         iCeRes,
    output logic                oBusy
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_CLEAR    = 4'd1;
    localparam logic [3:0] S_ROW_WAIT = 4'd2;
    localparam logic [3:0] S_LOAD3    = 4'd3;
    localparam logic [3:0] S_LOAD8    = 4'd4;
    localparam logic [3:0] S_CMP      = 4'd5;
    localparam logic [3:0] S_RD0      = 4'd6;
    localparam logic [3:0] S_RD1      = 4'd7;
    localparam logic [3:0] S_RD2      = 4'd8;
    localparam logic [3:0] S_RD3      = 4'd9;
    localparam logic [3:0] S_OUT      = 4'd10;

    localparam logic [3:0] LAST_ROW = 4'(WIN - 1);

    logic [3:0]         state_q, state_d;
    logic [3:0]         row_cnt_q, row_cnt_d;
    logic [8*WIN-1:0]   row_q, row_d;
    logic [7:0]         center_q, center_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic               clk_en_q, clk_en_d;

    logic               ce_start;
    logic [3:0]         ce_op;
    logic [31:0]        ce_a, ce_b;

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        row_d     = row_q;
        center_d  = center_q;
        code_d    = code_q;
        clk_en_d  = 1'b1;
        ce_start  = 1'b0;
        ce_op     = 4'd0;
        ce_a      = 32'd0;
        ce_b      = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (iEnable) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                ce_start  = 1'b1;
                ce_op     = 4'd0;
                row_cnt_d = 4'd0;
                state_d   = S_ROW_WAIT;
            end
            S_ROW_WAIT: begin
                if (iRowValid) begin
                    row_d = iRowData;
                    if (row_cnt_q == LAST_ROW) center_d = iCenter;
                    state_d = S_LOAD3;
                end
            end
            S_LOAD3: begin
                // top three pixels of the row; B tells the unit the row length
                ce_start = 1'b1;
                ce_op    = 4'd1;
                ce_a     = {8'h00, row_q[8*WIN-1:64]};
                ce_b     = 32'(WIN);
                state_d  = S_LOAD3 + 4'd1;
            end
            S_LOAD8: begin
                ce_start = 1'b1;
                ce_op    = 4'd2;
                ce_a     = row_q[31:0];
                ce_b     = row_q[63:32];
                if (row_cnt_q == LAST_ROW) begin
                    state_d = S_CMP;
                end else begin
                    row_cnt_d = row_cnt_q + 4'd1;
                    state_d   = S_ROW_WAIT;
                end
            end
            S_CMP: begin
                ce_start = 1'b1;
                ce_op    = 4'd3;
                ce_a     = {24'd0, center_q};
                state_d  = S_RD0;
            end
            // each read state captures the word produced by the op issued
            // in the previous cycle and issues the next read
            S_RD0: begin
                code_d[31:0] = iCeRes;
                ce_start     = 1'b1;
                ce_op        = 4'd5;
                state_d      = S_RD1;
            end
            S_RD1: begin
                code_d[63:32] = iCeRes;
                ce_start      = 1'b1;
                ce_op         = 4'd6;
                state_d       = S_RD2;
            end
            S_RD2: begin
                code_d[95:64] = iCeRes;
                ce_start      = 1'b1;
                ce_op         = 4'd7;
                state_d       = S_RD3;
            end
            S_RD3: begin
                code_d[CODE_W-1:96] = iCeRes[CODE_W-97:0];
                state_d             = S_OUT;
            end
            S_OUT: begin
                if (iCodeReady) state_d = iEnable ? S_CLEAR : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q   <= S_IDLE;
            row_cnt_q <= 4'd0;
            row_q     <= '0;
            center_q  <= 8'd0;
            code_q    <= '0;
            clk_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            row_q     <= row_d;
            center_q  <= center_d;
            code_q    <= code_d;
            clk_en_q  <= clk_en_d;
        end
    end

    // Reset masks the handshakes and the op strobe in the cycle it is
    // asserted, so a beat offered alongside reset is never consumed and
    // the unit sees nothing until the next CLEAR.
    assign oRowReady  = (state_q == S_ROW_WAIT) && !iReset;
    assign oCodeValid = (state_q == S_OUT) && !iReset;
    assign oCeStart   = ce_start && !iReset;
    assign oCeOp      = oCeStart ? ce_op : 4'd0;
    assign oCeA       = oCeStart ? ce_a  : 32'd0;
    assign oCeB       = oCeStart ? ce_b  : 32'd0;
    assign oCode      = code_q;
    assign oCeClkEn   = clk_en_q;
    assign oBusy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_census_win_seq.sv
module tb_census_win_seq;

    localparam logic [7:0]   CENTER   = 8'hC5;
    localparam logic [119:0] EXP_CODE = 120'h444444_33333333_22222222_11111111;

    logic         iClk = 1'b0;
    logic         iReset, iEnable, iRowValid, iCodeReady;
    logic [87:0]  iRowData;
    logic [7:0]   iCenter;
    logic         oRowReady, oCodeValid, oCeStart, oCeClkEn, oBusy;
    logic [119:0] oCode;
    logic [31:0]  oCeA, oCeB, iCeRes;
    logic [3:0]   oCeOp;

    census_win_seq dut (
        .iClk(iClk), .iReset(iReset), .iEnable(iEnable),
        .iRowData(iRowData), .iRowValid(iRowValid), .oRowReady(oRowReady),
        .iCenter(iCenter), .oCode(oCode), .oCodeValid(oCodeValid),
        .iCodeReady(iCodeReady), .oCeA(oCeA), .oCeB(oCeB), .oCeOp(oCeOp),
        .oCeStart(oCeStart), .oCeClkEn(oCeClkEn), .iCeRes(iCeRes), .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    // Census unit model: the result bus reflects the last op started.
    logic [3:0] last_op;
    always @(posedge iClk) begin
        if (iReset)        last_op <= 4'hF;
        else if (oCeStart) last_op <= oCeOp;
    end
    always_comb begin
        case (last_op)
            4'd3:    iCeRes = 32'h11111111;
            4'd5:    iCeRes = 32'h22222222;
            4'd6:    iCeRes = 32'h33333333;
            4'd7:    iCeRes = 32'hAA444444;
            default: iCeRes = 32'hDEADBEEF;
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [87:0] row_val(input int r);
        logic [87:0] v;
        for (int k = 0; k < 11; k++) v[8*k +: 8] = 8'(r * 16 + k);
        return v;
    endfunction

    logic [3:0]  op_q[$];
    logic [31:0] a_q[$];
    logic [31:0] b_q[$];
    int row_idx, zero_err, stable_err;

    // Runs one window from IDLE/CLEAR. gap_len: ROW_WAIT cycles with no beat
    // before row 4; rdy_wait: OUT cycles before ready; drop_row: drop iEnable
    // once this row is due (-1 = never); abort_op2: return just before the
    // edge of that LOAD8 (0 = never). t_valid counts edges until oCodeValid.
    task automatic run_window(input int gap_len, input int rdy_wait, input int drop_row,
                              input int abort_op2, output int t_valid, output logic [119:0] code0);
        int gap_left, wait_cnt, cyc, n2;
        bit done, rd_acc, cd_acc;
        op_q.delete(); a_q.delete(); b_q.delete();
        row_idx = 0; gap_left = gap_len; wait_cnt = 0; cyc = 0; n2 = 0; done = 0;
        t_valid = -1; code0 = '0; zero_err = 0; stable_err = 0;
        iEnable = 1'b1;
        while (!done && cyc < 300) begin
            if (drop_row >= 0 && row_idx >= drop_row) iEnable = 1'b0;
            iRowData  = row_val(row_idx);
            iCenter   = (row_idx == 10) ? CENTER : 8'h00;
            iRowValid = !(row_idx == 4 && gap_left > 0);
            if (oCodeValid) begin
                if (t_valid < 0) begin t_valid = cyc; code0 = oCode; end
                if (oCode !== code0 || oRowReady || oCeStart) stable_err++;
                iCodeReady = (wait_cnt >= rdy_wait);
                wait_cnt++;
            end else begin
                iCodeReady = 1'b0;
            end
            #1;
            if (oCeStart) begin
                op_q.push_back(oCeOp); a_q.push_back(oCeA); b_q.push_back(oCeB);
                if (oCeOp == 4'd2) n2++;
            end else if (oCeOp != 0 || oCeA != 0 || oCeB != 0) begin
                zero_err++;
            end
            if (!iRowValid && oRowReady) begin
                gap_left--;
                if (oCeStart) zero_err++;
            end
            if (abort_op2 > 0 && oCeStart && oCeOp == 4'd2 && n2 == abort_op2) return;
            rd_acc = oRowReady && iRowValid;
            cd_acc = oCodeValid && iCodeReady;
            @(negedge iClk);
            cyc++;
            if (rd_acc) row_idx++;
            if (cd_acc) done = 1;
        end
        chk("window_done", 128'(done), 128'd1);
    endtask

    task automatic verify_trace(input string tag);
        logic [3:0]  eop[$];
        logic [31:0] ea[$];
        logic [31:0] eb[$];
        logic [87:0] rv;
        int n;
        eop.push_back(4'd0); ea.push_back(32'd0); eb.push_back(32'd0);
        for (int r = 0; r < 11; r++) begin
            rv = row_val(r);
            eop.push_back(4'd1); ea.push_back({8'h00, rv[87:64]}); eb.push_back(32'd11);
            eop.push_back(4'd2); ea.push_back(rv[31:0]);           eb.push_back(rv[63:32]);
        end
        eop.push_back(4'd3); ea.push_back({24'd0, CENTER}); eb.push_back(32'd0);
        for (int i = 5; i <= 7; i++) begin
            eop.push_back(4'(i)); ea.push_back(32'd0); eb.push_back(32'd0);
        end
        chk({tag, "_nops"}, 128'(op_q.size()), 128'(eop.size()));
        n = (op_q.size() < eop.size()) ? op_q.size() : eop.size();
        for (int j = 0; j < n; j++) begin
            chk($sformatf("%s_op%0d", tag, j), 128'(op_q[j]), 128'(eop[j]));
            chk($sformatf("%s_a%0d", tag, j),  128'(a_q[j]),  128'(ea[j]));
            chk($sformatf("%s_b%0d", tag, j),  128'(b_q[j]),  128'(eb[j]));
        end
        chk({tag, "_idle_zero"}, 128'(zero_err), 128'd0);
        chk({tag, "_stable"}, 128'(stable_err), 128'd0);
    endtask

    task automatic do_reset(input int n);
        iReset = 1'b1;
        repeat (n) @(negedge iClk);
        iReset = 1'b0;
    endtask

    int t;
    logic [119:0] code;

    initial begin
        iReset = 1'b1; iEnable = 1'b0; iRowValid = 1'b1; iCodeReady = 1'b1;
        iRowData = row_val(0); iCenter = 8'h00;

        // reset held 3 cycles with a row offered
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk);
            chk($sformatf("rst_outs%0d", i),
                {oRowReady, oCodeValid, oCeStart, oCeClkEn, oBusy, oCeOp, oCode},
                128'd0);
            chk($sformatf("rst_ce%0d", i), {64'd0, oCeA, oCeB}, 128'd0);
        end
        iReset = 1'b0;
        @(negedge iClk);
        chk("clken_after_rst", 128'(oCeClkEn), 128'd1);
        chk("idle_busy", 128'(oBusy), 128'd0);
        chk("idle_rdy", 128'(oRowReady), 128'd0);

        // basic window, immediate ready, enable held -> next op is clear
        run_window(0, 0, -1, 0, t, code);
        chk("basic_lat", 128'(t), 128'd40);
        chk("basic_code", 128'(code), 128'(EXP_CODE));
        verify_trace("basic");
        #1;
        chk("basic_restart_start", 128'(oCeStart), 128'd1);
        chk("basic_restart_op", 128'(oCeOp), 128'd0);

        // 5-cycle row gap before row 4
        do_reset(2);
        run_window(5, 0, -1, 0, t, code);
        chk("gap_lat", 128'(t), 128'd45);
        chk("gap_code", 128'(code), 128'(EXP_CODE));
        verify_trace("gap");

        // downstream stalls 10 cycles in OUT
        do_reset(2);
        run_window(0, 10, -1, 0, t, code);
        chk("stall_lat", 128'(t), 128'd40);
        chk("stall_code", 128'(oCode), 128'(EXP_CODE));
        verify_trace("stall");
        #1;
        chk("stall_restart_start", 128'(oCeStart), 128'd1);
        chk("stall_restart_op", 128'(oCeOp), 128'd0);
        chk("stall_cv_drop", 128'(oCodeValid), 128'd0);

        // enable dropped during row 7
        do_reset(2);
        run_window(0, 0, 7, 0, t, code);
        chk("drop_code", 128'(code), 128'(EXP_CODE));
        verify_trace("drop");
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("drop_idle%0d", i), {oBusy, oCeStart, oCodeValid, oRowReady}, 128'd0);
            @(negedge iClk);
        end

        // reset during LOAD8 of row 6, then a full clean window
        do_reset(2);
        run_window(0, 0, -1, 7, t, code);
        iReset = 1'b1;
        @(negedge iClk);
        iReset = 1'b0;
        #1;
        chk("abort_outs", {oRowReady, oCodeValid, oCeStart, oCeClkEn, oBusy, oCeOp, oCode}, 128'd0);
        chk("abort_ce", {64'd0, oCeA, oCeB}, 128'd0);
        @(negedge iClk);
        run_window(0, 0, -1, 0, t, code);
        chk("abort_lat", 128'(t), 128'd39);
        chk("abort_code", 128'(code), 128'(EXP_CODE));
        verify_trace("abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/census_win_seq.md
Name: census_win_seq

Overview:
- Sequencer that drives the census/Hamming custom-instruction unit in the stereo pipeline.
- Accepts an 11x11 window of 8-bit pixels as 11 row beats, plus the centre pixel.
- Issues the unit's opcode sequence: clear, 3+8 byte loads per row, compare, then word reads.
- Assembles the 120-bit census code and hands it downstream with a valid/ready handshake, without CPU involvement.

Parameters:
- WIN, 11: window edge in pixels; only 11 supported (120-bit code, 22 load ops).
- CODE_W, 120: census code width, WIN*WIN-1.

Ports:
- iClk  in  1  clock.
- iReset  in  1  synchronous, active-high reset.
- iEnable  in  1  run windows continuously while high.
- iRowData  in  88  one window row; pixel k at [8k+7:8k].
- iRowValid  in  1  row beat valid.
- oRowReady  out  1  row beat accepted when high with iRowValid.
- iCenter  in  8  centre pixel; sampled on the accept of row 10.
- oCode  out  120  census code.
- oCodeValid  out  1  code valid.
- iCodeReady  in  1  downstream accepts code.
- oCeA  out  32  census unit operand A.
- oCeB  out  32  census unit operand B.
- oCeOp  out  4  census unit opcode.
- oCeStart  out  1  census unit start; one cycle per op.
- oCeClkEn  out  1  census unit clock enable.
- iCeRes  in  32  census unit result.
- oBusy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0, including oCode, oCeOp, oCeA and oCeB. Row counter is 0 and the state is IDLE.
- oCeClkEn goes to 1 on the first cycle after reset is released.
- States: IDLE, CLEAR, ROW_WAIT, LOAD3, LOAD8, CMP, RD0, RD1, RD2, RD3, OUT.
- IDLE -> CLEAR when iEnable=1.
- CLEAR: issue op 0 for one cycle, clear the row counter -> ROW_WAIT.
- ROW_WAIT:
  - oRowReady=1; no op issued.
  - On iRowValid, capture the row into a holding register (and iCenter if row counter=10) -> LOAD3.
  - oRowReady is 0 in every other state.
- LOAD3: op 1, oCeA={8'h00,row[87:64]}, oCeB=32'd11 -> LOAD8.
- LOAD8: op 2, oCeA=row[31:0], oCeB=row[63:32].
  - Row counter <10: increment, -> ROW_WAIT.
  - Row counter =10: -> CMP.
- CMP: op 3, oCeA={24'd0,center} -> RD0.
- RD0: code[31:0] <= iCeRes (combinational compare result); issue op 5 -> RD1.
- RD1: code[63:32] <= iCeRes; issue op 6 -> RD2.
- RD2: code[95:64] <= iCeRes; issue op 7 -> RD3.
- RD3: code[119:96] <= iCeRes[23:0]; no op -> OUT.
- OUT:
  - oCodeValid=1; oCode is held stable until iCodeReady.
  - On handshake: iEnable=1 -> CLEAR, else -> IDLE.
  - oCodeValid drops the cycle after the handshake.
- Op-issue rules:
  - oCeStart=1 only in CLEAR, LOAD3, LOAD8, CMP, RD0, RD1 and RD2.
  - oCeOp, oCeA and oCeB are 0 whenever oCeStart=0.
  - Result sampling is fixed latency; the unit's done signal is not used.
- Minimum window period with rows always valid: 1 + 11*3 + 1 + 4 + 1 = 40 cycles. Each cycle of iRowValid low in ROW_WAIT adds 1.
- iEnable deassert mid-window: the window completes through OUT, then the block goes to IDLE. iEnable is only examined in IDLE and on the OUT handshake.
- Reset mid-operation (any state):
  - All state returns to reset values at the next edge, and the partial window is discarded.
  - The census unit is not touched until the next CLEAR, so the first op after restart is always op 0.
- Simultaneous iReset and any handshake: reset wins and the beat is not accepted.
- No row beat is ever dropped. Back-pressure holds via oRowReady=0 whenever the block is not in ROW_WAIT.

Test Plan:
- Reset held 3 cycles with iRowValid=1 -> all outputs 0, oRowReady=0, no oCeStart.
- iEnable=1, rows always valid, model unit returns 32'h11111111, 32'h22222222, 32'h33333333, 32'hAA444444 in RD0..RD3 -> op trace 0,(1,2)x11,3,5,6,7; op 1 carries oCeB=11; op 3 carries oCeA=centre; oCode=120'h444444_33333333_22222222_11111111; oCodeValid first high 40 cycles after iEnable.
- iRowValid low for 5 cycles before row 4 -> no oCeStart during the gap; oCodeValid delayed to cycle 45.
- iCodeReady low for 10 cycles in OUT -> oCode stable, oRowReady=0, no ops issued; after the handshake, op 0 is issued the next cycle.
- iEnable dropped during row 7 -> window finishes, code delivered, state IDLE, oBusy=0.
- iReset pulsed during LOAD8 of row 6 -> next cycle all outputs 0; with iEnable high after release, first op is 0, followed by 11 full row loads.
